// File: rtl/uart_rx_prog_loader.sv
// 8N1 UART receiver that pairs bytes (low first) into instruction words and
// writes them to program memory from address 0 until a halt word or a full memory.
module uart_rx_prog_loader #(
  parameter int DBIT      = 8,
  parameter int SB_TICK   = 16,
  parameter int NBITS_D   = 16,
  parameter int OPCODE    = 5,
  parameter int NBITS_A   = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx,
  input  logic               i_s_tick,
  input  logic               i_start_load,
  output logic               o_mem_we,
  output logic [NBITS_A-1:0] o_mem_addr,
  output logic [NBITS_D-1:0] o_mem_data,
  output logic               o_busy,
  output logic               o_load_done,
  output logic               o_frame_err,
  output logic [NBITS_A:0]   o_word_count
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam int SW = $clog2((SB_TICK > 16) ? SB_TICK : 16);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {A_IDLE, A_LOW, A_HIGH, A_WRITE, A_DONE} asm_state_t;

  logic            rx_meta_reg, rx_sync_reg;
  rx_state_t       rx_state_reg;
  logic [SW-1:0]   s_reg;
  logic [NW-1:0]   n_reg;
  logic [DBIT-1:0] b_reg;
  logic            byte_valid_reg, ferr_pulse_reg;

  asm_state_t      asm_state_reg;
  logic [DBIT-1:0] low_reg;
  logic            we_reg, busy_reg, done_reg, ferr_reg;
  logic [NBITS_A-1:0] addr_reg;
  logic [NBITS_D-1:0] data_reg;
  logic [NBITS_A:0]   count_reg;

  logic halt_word, last_word;
  assign halt_word = (data_reg[NBITS_D-1 -: OPCODE] == '0);
  assign last_word = (count_reg == (NBITS_A+1)'(MAX_WORDS - 1));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= i_rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // Receiver: start bit checked at mid-bit, data and stop bits one bit period apart.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_state_reg   <= RX_IDLE;
      s_reg          <= '0;
      n_reg          <= '0;
      b_reg          <= '0;
      byte_valid_reg <= 1'b0;
      ferr_pulse_reg <= 1'b0;
    end else begin
      byte_valid_reg <= 1'b0;
      ferr_pulse_reg <= 1'b0;
      case (rx_state_reg)
        RX_IDLE: begin
          if (!rx_sync_reg) begin
            rx_state_reg <= RX_START;
            s_reg        <= '0;
          end
        end
        RX_START: begin
          if (i_s_tick) begin
            if (s_reg == SW'(7)) begin
              s_reg <= '0;
              n_reg <= '0;
              rx_state_reg <= rx_sync_reg ? RX_IDLE : RX_DATA;
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        RX_DATA: begin
          if (i_s_tick) begin
            if (s_reg == SW'(15)) begin
              s_reg <= '0;
              b_reg <= {rx_sync_reg, b_reg[DBIT-1:1]};
              if (n_reg == NW'(DBIT - 1))
                rx_state_reg <= RX_STOP;
              else
                n_reg <= n_reg + 1'b1;
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (i_s_tick) begin
            if (s_reg == SW'(SB_TICK - 1)) begin
              byte_valid_reg <= rx_sync_reg;
              ferr_pulse_reg <= !rx_sync_reg;
              rx_state_reg   <= RX_IDLE;
            end else begin
              s_reg <= s_reg + 1'b1;
            end
          end
        end
        default: rx_state_reg <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      asm_state_reg <= A_IDLE;
      low_reg       <= '0;
      we_reg        <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      ferr_reg      <= 1'b0;
      addr_reg      <= '0;
      data_reg      <= '0;
      count_reg     <= '0;
    end else begin
      we_reg <= 1'b0;
      case (asm_state_reg)
        A_IDLE, A_DONE: begin
          if (i_start_load) begin
            asm_state_reg <= A_LOW;
            addr_reg      <= '0;
            count_reg     <= '0;
            ferr_reg      <= 1'b0;
            done_reg      <= 1'b0;
            busy_reg      <= 1'b1;
          end
        end
        A_LOW: begin
          if (ferr_pulse_reg) begin
            ferr_reg <= 1'b1;
          end else if (byte_valid_reg) begin
            low_reg       <= b_reg;
            asm_state_reg <= A_HIGH;
          end
        end
        A_HIGH: begin
          if (ferr_pulse_reg) begin
            ferr_reg      <= 1'b1;
            asm_state_reg <= A_LOW;
          end else if (byte_valid_reg) begin
            data_reg      <= {b_reg, low_reg};
            we_reg        <= 1'b1;
            asm_state_reg <= A_WRITE;
          end
        end
        A_WRITE: begin
          count_reg <= count_reg + 1'b1;
          // Hold the address on the final slot so it never wraps to 0.
          if (!last_word)
            addr_reg <= addr_reg + 1'b1;
          if (halt_word || last_word) begin
            asm_state_reg <= A_DONE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
          end else begin
            asm_state_reg <= A_LOW;
          end
        end
        default: asm_state_reg <= A_IDLE;
      endcase
    end
  end

  assign o_mem_we     = we_reg;
  assign o_mem_addr   = addr_reg;
  assign o_mem_data   = data_reg;
  assign o_busy       = busy_reg;
  assign o_load_done  = done_reg;
  assign o_frame_err  = ferr_reg;
  assign o_word_count = count_reg;

endmodule

// File: tb/tb_uart_rx_prog_loader.sv
// Directed bench for uart_rx_prog_loader: 16 clk per bit, MAX_WORDS reduced to 4.
module tb_uart_rx_prog_loader;

  logic        clk = 1'b0;
  logic        srst, rx, tick, start_load;
  logic        mem_we, busy, load_done, frame_err;
  logic [9:0]  mem_addr;
  logic [15:0] mem_data;
  logic [10:0] word_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_addr[$];
  int wr_data[$];
  int wr_cyc[$];

  uart_rx_prog_loader #(.MAX_WORDS(4)) dut (
    .i_clk(clk), .i_reset(srst), .i_rx(rx), .i_s_tick(tick),
    .i_start_load(start_load), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_data(mem_data), .o_busy(busy), .o_load_done(load_done),
    .o_frame_err(frame_err), .o_word_count(word_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(int'(mem_data));
      wr_cyc.push_back(cyc);
      $display("WRITE addr=%0d data=%h cycle=%0d", mem_addr, mem_data, cyc);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    srst = 1'b1; rx = 1'b1; start_load = 1'b0;
    wait_cycles(3);
    srst = 1'b0;
    wait_cycles(2);
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
  endtask

  task automatic arm();
    start_load = 1'b1;
    wait_cycles(1);
    start_load = 1'b0;
  endtask

  // t0 is the cycle count at the negedge where the start bit is driven
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int idle, output int t0);
    t0 = cyc;
    rx = 1'b0;
    wait_cycles(16);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_cycles(16);
    end
    rx = stop_bit;
    wait_cycles(16);
    rx = 1'b1;
    wait_cycles(idle);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", mem_we); end
    checks++; if (mem_addr !== 10'd0) begin errors++; $display("FAIL reset_addr got %0d exp 0", mem_addr); end
    checks++; if (mem_data !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", mem_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (load_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", load_done); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
    checks++; if (word_count !== 11'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", word_count); end
  endtask

  task automatic test_basic();
    int t, t_hi;
    int exp_a[2] = '{0, 1};
    int exp_d[2] = '{16'h1234, 16'h0000};
    do_reset();
    arm();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_armed got %b exp 1", busy); end
    send_byte(8'h34, 1'b1, 2, t);
    send_byte(8'h12, 1'b1, 2, t_hi);
    send_byte(8'h00, 1'b1, 2, t);
    send_byte(8'h00, 1'b1, 10, t);
    checks++; if (wr_addr.size() != 2) begin errors++; $display("FAIL basic_nwrites got %0d exp 2", wr_addr.size()); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= wr_addr.size()) begin errors++; $display("FAIL basic_write%0d got none exp addr %0d", i, exp_a[i]); end
      else if (wr_addr[i] != exp_a[i] || wr_data[i] != exp_d[i]) begin
        errors++; $display("FAIL basic_write%0d got %0d/%h exp %0d/%h", i, wr_addr[i], wr_data[i], exp_a[i], exp_d[i]);
      end
    end
    // stop-bit sample lands on the 155th edge of the frame; we is high after the 156th
    checks++;
    if (wr_cyc.size() < 1 || wr_cyc[0] != t_hi + 156) begin
      errors++; $display("FAIL basic_latency got %0d exp %0d", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, t_hi + 156);
    end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL basic_done got %b exp 1", load_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy got %b exp 0", busy); end
    checks++; if (word_count !== 11'd2) begin errors++; $display("FAIL basic_count got %0d exp 2", word_count); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL basic_ferr got %b exp 0", frame_err); end
  endtask

  task automatic test_frame_err();
    int t;
    do_reset();
    arm();
    send_byte(8'hAB, 1'b1, 2, t);
    send_byte(8'hCD, 1'b0, 40, t);
    send_byte(8'h01, 1'b1, 2, t);
    send_byte(8'h08, 1'b1, 10, t);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag got %b exp 1", frame_err); end
    checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL ferr_nwrites got %0d exp 1", wr_addr.size()); end
    checks++;
    if (wr_addr.size() < 1 || wr_addr[0] != 0 || wr_data[0] != 16'h0801) begin
      errors++; $display("FAIL ferr_write got %0d/%h exp 0/0801",
        (wr_addr.size() > 0) ? wr_addr[0] : -1, (wr_data.size() > 0) ? wr_data[0] : -1);
    end
    checks++; if (busy !== 1'b1 || load_done !== 1'b0) begin errors++; $display("FAIL ferr_state got busy %b done %b exp 1 0", busy, load_done); end
  endtask

  task automatic test_glitch();
    int t;
    do_reset();
    arm();
    rx = 1'b0;
    wait_cycles(4);
    rx = 1'b1;
    wait_cycles(30);
    send_byte(8'h55, 1'b1, 2, t);
    send_byte(8'hF8, 1'b1, 10, t);
    checks++; if (wr_addr.size() != 1) begin errors++; $display("FAIL glitch_nwrites got %0d exp 1", wr_addr.size()); end
    checks++;
    if (wr_addr.size() < 1 || wr_addr[0] != 0 || wr_data[0] != 16'hF855) begin
      errors++; $display("FAIL glitch_write got %0d/%h exp 0/f855",
        (wr_addr.size() > 0) ? wr_addr[0] : -1, (wr_data.size() > 0) ? wr_data[0] : -1);
    end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL glitch_ferr got %b exp 0", frame_err); end
  endtask

  task automatic test_max_words();
    int t;
    do_reset();
    arm();
    for (int w = 0; w < 4; w++) begin
      send_byte(8'h01, 1'b1, 2, t);
      send_byte(8'h08, 1'b1, 2, t);
    end
    wait_cycles(8);
    checks++; if (wr_addr.size() != 4) begin errors++; $display("FAIL max_nwrites got %0d exp 4", wr_addr.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= wr_addr.size()) begin errors++; $display("FAIL max_write%0d got none exp %0d/0801", i, i); end
      else if (wr_addr[i] != i || wr_data[i] != 16'h0801) begin
        errors++; $display("FAIL max_write%0d got %0d/%h exp %0d/0801", i, wr_addr[i], wr_data[i], i);
      end
    end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL max_done got %b exp 1", load_done); end
    checks++; if (word_count !== 11'd4) begin errors++; $display("FAIL max_count got %0d exp 4", word_count); end
    send_byte(8'h01, 1'b1, 2, t);
    send_byte(8'h08, 1'b1, 10, t);
    checks++; if (wr_addr.size() != 4) begin errors++; $display("FAIL max_after_done got %0d writes exp 4", wr_addr.size()); end
  endtask

  task automatic test_pre_arm();
    int t;
    do_reset();
    send_byte(8'h11, 1'b1, 2, t);
    send_byte(8'h22, 1'b1, 10, t);
    checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL prearm_nwrites got %0d exp 0", wr_addr.size()); end
    arm();
    send_byte(8'h00, 1'b1, 2, t);
    send_byte(8'h00, 1'b1, 10, t);
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] != 0 || wr_data[0] != 0) begin
      errors++; $display("FAIL prearm_write got %0d writes exp 1 at 0/0000", wr_addr.size());
    end
    checks++; if (load_done !== 1'b1) begin errors++; $display("FAIL prearm_done got %b exp 1", load_done); end
    checks++; if (word_count !== 11'd1) begin errors++; $display("FAIL prearm_count got %0d exp 1", word_count); end
  endtask

  task automatic test_reset_mid_word();
    int t;
    do_reset();
    arm();
    send_byte(8'h34, 1'b1, 2, t);
    rx = 1'b0;
    wait_cycles(40);
    rx = 1'b1;
    wait_cycles(20);
    srst = 1'b1;
    wait_cycles(1);
    srst = 1'b0;
    checks++;
    if (mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_data !== 16'h0 || busy !== 1'b0 ||
        load_done !== 1'b0 || frame_err !== 1'b0 || word_count !== 11'd0) begin
      errors++; $display("FAIL midreset_outputs got we %b addr %0d data %h busy %b done %b ferr %b cnt %0d exp all 0",
        mem_we, mem_addr, mem_data, busy, load_done, frame_err, word_count);
    end
    wait_cycles(200);
    checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL midreset_nwrites got %0d exp 0", wr_addr.size()); end
    arm();
    send_byte(8'h34, 1'b1, 2, t);
    send_byte(8'h12, 1'b1, 10, t);
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] != 0 || wr_data[0] != 16'h1234) begin
      errors++; $display("FAIL midreset_rewrite got %0d writes exp 1 at 0/1234", wr_addr.size());
    end
    // Arm while busy must not restart the address.
    arm();
    send_byte(8'h00, 1'b1, 2, t);
    send_byte(8'h00, 1'b1, 10, t);
    checks++;
    if (wr_addr.size() != 2 || wr_addr[1] != 1 || wr_data[1] != 0) begin
      errors++; $display("FAIL busy_arm_ignored got %0d writes (last addr %0d) exp 2 with addr 1",
        wr_addr.size(), (wr_addr.size() > 0) ? wr_addr[wr_addr.size()-1] : -1);
    end
    checks++; if (word_count !== 11'd2 || load_done !== 1'b1) begin errors++; $display("FAIL busy_arm_count got %0d done %b exp 2 1", word_count, load_done); end
  endtask

  initial begin
    srst = 1'b1; rx = 1'b1; tick = 1'b1; start_load = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_frame_err();
    test_glitch();
    test_max_words();
    test_pre_arm();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
